// File: rtl/guess_pkg.sv
// Shared encodings for the number-guessing judge: result codes and FSM states.
package guess_pkg;

    localparam logic [1:0] RES_OK   = 2'b00;
    localparam logic [1:0] RES_UP   = 2'b01;
    localparam logic [1:0] RES_DOWN = 2'b10;
    localparam logic [1:0] RES_OOR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } state_t;

endpackage

// File: rtl/range_compare.sv
// Classifies a guess against the secret and the still-possible window [low, high].
module range_compare
    import guess_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] i_guess,
    input  logic [WIDTH-1:0] i_secret,
    input  logic [WIDTH-1:0] i_low,
    input  logic [WIDTH-1:0] i_high,
    output logic [1:0]       o_result
);

    always_comb begin
        o_result = RES_DOWN;
        if ((i_guess < i_low) || (i_guess > i_high)) begin
            o_result = RES_OOR;
        end else if (i_guess == i_secret) begin
            o_result = RES_OK;
        end else if (i_guess < i_secret) begin
            o_result = RES_UP;
        end
    end

endmodule

// File: rtl/guess_judge.sv
// Guessing-game referee: tracks the secret, narrows the possible window per guess,
// counts tries and declares WIN or LOSE.
//   state | meaning
//   IDLE  | no game since reset
//   PLAY  | accepting guesses
//   WIN   | secret was hit
//   LOSE  | MAX_TRIES counted guesses used without a hit
module guess_judge
    import guess_pkg::*;
#(
    parameter int WIDTH     = 7,
    parameter int MAX_TRIES = 10,
    parameter int TRY_W     = $clog2(MAX_TRIES + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_secret,
    input  logic             i_guess_valid,
    input  logic [WIDTH-1:0] i_guess,
    output logic             o_guess_ready,
    output logic             o_result_valid,
    output logic [1:0]       o_result,
    output logic [WIDTH-1:0] o_low_bound,
    output logic [WIDTH-1:0] o_high_bound,
    output logic [TRY_W-1:0] o_tries,
    output logic             o_win,
    output logic             o_lose
);

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_secret, w_secret_nxt;
    logic [WIDTH-1:0]   r_low, w_low_nxt;
    logic [WIDTH-1:0]   r_high, w_high_nxt;
    logic [TRY_W-1:0]   r_tries, w_tries_nxt;
    logic [1:0]         r_result, w_result_nxt;
    logic               r_result_valid, w_result_valid_nxt;
    logic [1:0]         w_class;
    logic               w_accept;
    logic [TRY_W-1:0]   w_tries_inc;

    range_compare #(.WIDTH(WIDTH)) u_range_compare (
        .i_guess  (i_guess),
        .i_secret (r_secret),
        .i_low    (r_low),
        .i_high   (r_high),
        .o_result (w_class)
    );

    assign w_accept    = i_guess_valid && (r_state == ST_PLAY) && !i_start;
    assign w_tries_inc = r_tries + TRY_W'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_secret       <= '0;
            r_low          <= '0;
            r_high         <= '0;
            r_tries        <= '0;
            r_result       <= RES_OK;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_secret       <= w_secret_nxt;
            r_low          <= w_low_nxt;
            r_high         <= w_high_nxt;
            r_tries        <= w_tries_nxt;
            r_result       <= w_result_nxt;
            r_result_valid <= w_result_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_secret_nxt       = r_secret;
        w_low_nxt          = r_low;
        w_high_nxt         = r_high;
        w_tries_nxt        = r_tries;
        w_result_nxt       = r_result;
        w_result_valid_nxt = 1'b0;
        if (i_start) begin
            w_state_nxt  = ST_PLAY;
            w_secret_nxt = i_secret;
            w_low_nxt    = '0;
            w_high_nxt   = '1;
            w_tries_nxt  = '0;
        end else if (w_accept) begin
            w_result_valid_nxt = 1'b1;
            w_result_nxt       = w_class;
            if (w_class != RES_OOR) begin
                w_tries_nxt = w_tries_inc;
                // A hit on the final try is still a win, so only misses can lose.
                if (w_class == RES_OK) begin
                    w_state_nxt = ST_WIN;
                end else if (w_tries_inc == TRY_W'(MAX_TRIES)) begin
                    w_state_nxt = ST_LOSE;
                end
                if (w_class == RES_UP) begin
                    w_low_nxt = i_guess + WIDTH'(1);
                end
                if (w_class == RES_DOWN) begin
                    w_high_nxt = i_guess - WIDTH'(1);
                end
            end
        end
    end

    assign o_guess_ready  = (r_state == ST_PLAY);
    assign o_result_valid = r_result_valid;
    assign o_result       = r_result;
    assign o_low_bound    = r_low;
    assign o_high_bound   = r_high;
    assign o_tries        = r_tries;
    assign o_win          = (r_state == ST_WIN);
    assign o_lose         = (r_state == ST_LOSE);

endmodule

// File: doc/guess_judge.md
GUESS_JUDGE -- requirements
Module: guess_judge

Interface
REQ-001 Parameter WIDTH, default 7, bit width of secret, guess and bounds; legal range 2..16.
REQ-002 Parameter MAX_TRIES, default 10, number of counted guesses allowed per game; legal range 1..255.
REQ-003 Parameter TRY_W, default $clog2(MAX_TRIES+1), width of tries output.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; capture secret and begin a new game.
REQ-007 secret  in  WIDTH  target number, sampled only when start=1.
REQ-008 guess_valid  in  1  guess offered this cycle.
REQ-009 guess  in  WIDTH  guessed number.
REQ-010 guess_ready  out  1  1 only in PLAY; guess accepted when guess_valid & guess_ready & !start.
REQ-011 result_valid  out  1  one-cycle pulse, one cycle after each accepted guess.
REQ-012 result  out  2  00 correct, 01 UP (secret > guess), 10 DOWN (secret < guess), 11 out-of-range; held until next result_valid.
REQ-013 low_bound  out  WIDTH  lowest still-possible value.
REQ-014 high_bound  out  WIDTH  highest still-possible value.
REQ-015 tries  out  TRY_W  counted guesses in current game.
REQ-016 win  out  1  high in WIN state.
REQ-017 lose  out  1  high in LOSE state.

Function
REQ-018 State machine SHALL have states IDLE, PLAY, WIN, LOSE.
REQ-019 start in any state SHALL, next edge: secret register=secret, low_bound=0, high_bound=2^WIDTH-1, tries=0, result_valid=0, state=PLAY.
REQ-020 start SHALL take priority over a same-cycle guess_valid; that guess is dropped and produces no result_valid.
REQ-021 Accepted guess outside [low_bound, high_bound] SHALL give result=11, bounds and tries unchanged, state stays PLAY.
REQ-022 Accepted in-range guess SHALL increment tries by 1 in the same edge that registers result.
REQ-023 In-range guess == secret SHALL give result=00 and state=WIN.
REQ-024 In-range guess < secret SHALL give result=01 and low_bound=guess+1.
REQ-025 In-range guess > secret SHALL give result=10 and high_bound=guess-1.
REQ-026 Non-correct in-range guess that brings tries to MAX_TRIES SHALL still report 01/10 and update bounds, and state SHALL become LOSE.
REQ-027 Correct guess on try MAX_TRIES SHALL give WIN, not LOSE.
REQ-028 Bound arithmetic SHALL be WIDTH bits with no wrap; guess+1 and guess-1 cannot overflow because in-range UP implies guess<2^WIDTH-1 and DOWN implies guess>0.
REQ-029 Latency: accepted guess at edge N SHALL produce result, bounds, tries, win/lose and result_valid=1 visible after edge N; at most one accepted guess per cycle, back-to-back accepted.
REQ-030 In IDLE, WIN, LOSE guess_valid SHALL be ignored and no result_valid pulse generated.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, result_valid=0, result=00, low_bound=0, high_bound=0, tries=0, win=0, lose=0, guess_ready=0, secret register=0.
REQ-032 Reset mid-game SHALL discard the game; only start resumes play after rst deasserts.

Structure
REQ-033 Shared package guess_pkg SHALL hold result encodings (RES_OK, RES_UP, RES_DOWN, RES_OOR) and the state enumeration.
REQ-034 Combinational sub-module range_compare (parameter WIDTH; inputs guess, secret, low, high; output 2-bit result) SHALL perform classification; guess_judge holds all registers.

Verification (WIDTH=7, MAX_TRIES=10)
REQ-035 rst, start secret=42, guess 42 -> next cycle result_valid=1, result=00, tries=1, win=1, guess_ready=0.
REQ-036 secret=42, guess 85 then 21 back-to-back -> results 10 then 01, high_bound=84, low_bound=22, tries=2.
REQ-037 Continuing REQ-036, guess 100 -> result=11, bounds 22..84 unchanged, tries=2.
REQ-038 secret=127, guesses 0..9 -> ten results 01, low_bound=10, tries=10, lose=1, further guess_valid ignored.
REQ-039 Mid-game start=1 with guess_valid=1, secret=5 -> no result_valid, tries=0, bounds 0..127, PLAY; guess 5 then gives 00.
REQ-040 rst asserted between edges mid-game -> all outputs at REQ-031 values before next clk edge.
